// File: rtl/div_pkg.sv
// Shared constants for the MIPS32 multi-cycle divider: FSM encodings,
// handshake levels and the sign-fixup helper.
package div_pkg;

    localparam logic       RstEnable         = 1'b0;

    localparam logic [1:0] DivFree           = 2'b00;
    localparam logic [1:0] DivByZero         = 2'b01;
    localparam logic [1:0] DivOn             = 2'b10;
    localparam logic [1:0] DivEnd            = 2'b11;

    localparam logic       DivResultReady    = 1'b1;
    localparam logic       DivResultNotReady = 1'b0;
    localparam logic       DivStart          = 1'b1;
    localparam logic       DivStop           = 1'b0;

    localparam logic [5:0] DivIterations     = 6'd32;

    // Two's-complement negation when neg is set, identity otherwise.
    function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] value);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: 32 shift-subtract iterations plus a
// sign-fixup cycle, returning {remainder, quotient} with a held ready flag.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor;
    logic        signed_q;
    logic        sign1;
    logic        sign2;

    logic [32:0] diff;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [31:0] quotient_fix;
    logic [31:0] remainder_fix;

    always_comb begin
        diff          = {1'b0, work[63:32]} - {1'b0, divisor};
        dividend_abs  = cond_neg(signed_div_i & opdata1_i[31], opdata1_i);
        divisor_abs   = cond_neg(signed_div_i & opdata2_i[31], opdata2_i);
        quotient_fix  = cond_neg(signed_q & (sign1 ^ sign2), work[31:0]);
        remainder_fix = cond_neg(signed_q & sign1, work[64:33]);
    end

    // NOTE: every register here is updated with <= so all branches read the
    // pre-edge state; blocking writes would make the iteration order-dependent.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            signed_q <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    cnt      <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= DivByZero;
                        end else begin
                            state    <= DivOn;
                            signed_q <= signed_div_i;
                            sign1    <= opdata1_i[31];
                            sign2    <= opdata2_i[31];
                            divisor  <= divisor_abs;
                            work     <= {32'd0, dividend_abs, 1'b0};
                        end
                    end
                end

                DivByZero: begin
                    work  <= '0;
                    state <= DivEnd;
                end

                DivOn: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                        cnt      <= '0;
                    end else if (cnt != DivIterations) begin
                        // A borrow out of the trial subtract means restore (shift only).
                        if (diff[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {diff[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {remainder_fix, quotient_fix};
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                        cnt      <= '0;
                    end
                end

                default: begin
                    // Hold the result until the execute stage drops its request.
                    if (start_i == DivStop || annul_i) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o  <= DivResultReady;
                    end
                end
            endcase
        end
    end

endmodule
